cycle_controller: RTL and testbench
===================================

# cycle_controller

Instruction-cycle sequencer for the CPU control path. Generates the 3-bit timing-step code that feeds the 3-to-8 step decoder, which expands it into T0–T7 one-hot timing strobes. Handles run/halt, instruction-granular single-stepping, memory wait stalls and variable-length instructions, and keeps a retired-instruction count.

## Interface

Parameters:
- STEP_W, 3, width of step code (matches decoder input count)
- MAX_STEP, 7, last legal step; an instruction ends here at the latest
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  pulse; begin or resume execution from IDLE or HALTED
- halt_req  input  1  pulse; request halt at next instruction boundary
- single_step  input  1  level; pause after every instruction
- step_pulse  input  1  pulse; release one instruction while paused
- mem_wait  input  1  level; current step not complete, hold step
- instr_done  input  1  current instruction finishes at end of this step
- step  output  STEP_W  current timing step, to decoder {in2,in1,in0}
- step_valid  output  1  step code is live; decoder outputs qualified by this
- fetch_start  output  1  one-cycle pulse on first cycle of step 0
- halted  output  1  high while in HALTED
- instr_count  output  CNT_W  retired instructions, wraps

One clock; reset is asynchronous and active-low.

## Operation

- States: IDLE, RUN, PAUSE, HALTED. Encoded in shared enum.
- Reset (async, immediate): state=IDLE, step=0, step_valid=0, fetch_start=0, halted=0, instr_count=0, halt_pending=0.
- IDLE: step_valid=0. start -> RUN, step=0.
- RUN: step_valid=1. Each cycle with mem_wait=0 the step completes:
  - instr_done=1 or step==MAX_STEP -> instruction boundary: instr_count+1 (wraps 2^CNT_W-1 -> 0).
  - otherwise step <= step+1.
- Boundary next state, priority order: halt_pending -> HALTED; single_step=1 -> PAUSE; else RUN at step 0.
- mem_wait=1 in RUN: step, state, counter held; instr_done ignored that cycle.
- halt_req: sets halt_pending in any state except IDLE; also sets it if coincident with start in IDLE (first instruction then halts). Cleared on entry to HALTED.
- PAUSE: step_valid=0, step=0. step_pulse -> RUN step 0; single_step deasserted -> RUN step 0; halt_req -> HALTED (priority over both).
- HALTED: halted=1, step_valid=0, step=0. start -> RUN step 0; instr_count retained.
- start in RUN or PAUSE ignored. step_pulse outside PAUSE ignored. instr_done outside RUN ignored.

## Timing

- All outputs registered; no combinational input-to-output paths.
- start at edge N (IDLE) -> step_valid=1, step=0, fetch_start=1 after edge N+1.
- fetch_start high exactly one cycle per step-0 entry, even if mem_wait holds step 0 for many cycles.
- Boundary at edge N -> next step 0 (or PAUSE/HALTED) visible after edge N+1; no bubble between back-to-back instructions in RUN.
- instr_count updates same edge as boundary.
- Maximum instruction length MAX_STEP+1 non-stalled cycles.
- Reset deassertion synchronous to clk externally; first start honoured on the first edge after release.

## Structure

- Shared package cpu_ctrl_pkg: state enum (IDLE, RUN, PAUSE, HALTED), STEP_W, MAX_STEP defaults.
- Single module, no sub-modules; next-state logic and registered outputs in one block, counter inline.
- Downstream decoder instantiated by parent; cycle_controller does not gate decoder outputs itself.

## Test plan

- Reset then start, instr_done at step 3, mem_wait=0 -> steps 0,1,2,3,0 repeating; fetch_start at each step 0; instr_count increments every 4 cycles.
- No instr_done -> steps 0..7 then 0; count +1 per 8 cycles; mem_wait high 5 cycles at step 2 -> step holds 2, single fetch_start per instruction.
- halt_req mid-instruction at step 1, instr_done at step 4 -> completes step 4, HALTED next cycle, halted=1, step_valid=0; start -> resumes at step 0, count preserved.
- single_step=1 -> PAUSE after each instruction; step_pulse -> exactly one instruction executes; halt_req in PAUSE -> HALTED.
- CNT_W=4, run 17 instructions -> instr_count 15 then 0 then 1.
- reset_n asserted at step 5 with mem_wait=1 -> all outputs to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control-path definitions: cycle sequencer state encoding and step-code defaults.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_HALTED = 2'd3
  } cyc_state_e;

  localparam int STEP_W_DEF   = 3;
  localparam int MAX_STEP_DEF = 7;

endpackage

// File: rtl/cycle_controller.sv
// Instruction-cycle sequencer: produces the timing-step code for the T0-T7 step decoder,
// with run/halt, instruction-granular single-step, memory-wait stalls and a retired count.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | after reset, nothing executing; start begins at step 0
// ST_RUN    | stepping through an instruction, step code live
// ST_PAUSE  | single-step boundary reached; waiting for step_pulse
// ST_HALTED | stopped at a boundary after halt_req; start resumes
module cycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              single_step,
  input  logic              step_pulse,
  input  logic              mem_wait,
  input  logic              instr_done,
  output logic [STEP_W-1:0] step,
  output logic              step_valid,
  output logic              fetch_start,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEP);

  cyc_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_d;
  logic              valid_d, fetch_d, halted_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              halt_pending, pend_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      step         <= '0;
      step_valid   <= 1'b0;
      fetch_start  <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= '0;
      halt_pending <= 1'b0;
    end else begin
      state_q      <= state_d;
      step         <= step_d;
      step_valid   <= valid_d;
      fetch_start  <= fetch_d;
      halted       <= halted_d;
      instr_count  <= cnt_d;
      halt_pending <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step;
    valid_d  = step_valid;
    fetch_d  = 1'b0;
    halted_d = halted;
    cnt_d    = instr_count;
    // a halt request coincident with the first start still stops after that instruction
    pend_d   = halt_pending | (halt_req & ((state_q != ST_IDLE) | start));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          step_d  = '0;
          valid_d = 1'b1;
          fetch_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!mem_wait) begin
          if (instr_done || (step == LAST_STEP)) begin
            cnt_d  = instr_count + CNT_W'(1);
            step_d = '0;
            if (halt_pending) begin
              state_d  = ST_HALTED;
              valid_d  = 1'b0;
              halted_d = 1'b1;
              pend_d   = 1'b0;
            end else if (single_step) begin
              state_d = ST_PAUSE;
              valid_d = 1'b0;
            end else begin
              fetch_d = 1'b1;
            end
          end else begin
            step_d = step + STEP_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (halt_req) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
          pend_d   = 1'b0;
        end else if (step_pulse || !single_step) begin
          state_d = ST_RUN;
          step_d  = '0;
          valid_d = 1'b1;
          fetch_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_d  = ST_RUN;
          step_d   = '0;
          valid_d  = 1'b1;
          fetch_d  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cycle_controller.sv
// Self-checking bench for cycle_controller: directed scenarios plus random stimulus,
// compared every cycle against an instruction-level reference model.
module tb_cycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, halt_req = 1'b0, single_step = 1'b0;
  logic          step_pulse = 1'b0, mem_wait = 1'b0, instr_done = 1'b0;
  logic [2:0]    step;
  logic          step_valid, fetch_start, halted;
  logic [CW-1:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  cycle_controller #(.STEP_W(3), .MAX_STEP(7), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .single_step(single_step), .step_pulse(step_pulse), .mem_wait(mem_wait),
    .instr_done(instr_done), .step(step), .step_valid(step_valid),
    .fetch_start(fetch_start), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Reference model: the sequencer's mode, position inside the instruction and retired count.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_HALT} mode_t;
  mode_t m_mode;
  int    m_step, m_count;
  bit    m_fetch, m_pend;

  task automatic model_reset();
    m_mode = M_IDLE; m_step = 0; m_count = 0; m_fetch = 0; m_pend = 0;
  endtask

  task automatic enter_run();
    m_mode = M_RUN; m_step = 0; m_fetch = 1;
  endtask

  task automatic enter_halt();
    m_mode = M_HALT; m_step = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    bit was_pend;
    was_pend = m_pend;
    m_fetch  = 0;
    if (halt_req && (m_mode != M_IDLE || start)) m_pend = 1;
    case (m_mode)
      M_IDLE:  if (start) enter_run();
      M_RUN: begin
        if (!mem_wait) begin
          if (instr_done || m_step == 7) begin
            m_count = (m_count + 1) % (1 << CW);
            m_step  = 0;
            if (was_pend) enter_halt();
            else if (single_step) m_mode = M_PAUSE;
            else m_fetch = 1;
          end else begin
            m_step = m_step + 1;
          end
        end
      end
      M_PAUSE: begin
        if (halt_req) enter_halt();
        else if (step_pulse || !single_step) enter_run();
      end
      M_HALT:  if (start) enter_run();
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [9:0] obs();
    return {step, step_valid, fetch_start, halted, instr_count};
  endfunction

  function automatic logic [9:0] expv();
    logic [2:0] s;
    logic [3:0] c;
    s = 3'(m_step);
    c = 4'(m_count);
    return {s, m_mode == M_RUN, m_fetch, m_mode == M_HALT, c};
  endfunction

  // Inputs change only right after the falling edge; DUT is sampled on the next falling edge.
  task automatic clock_it();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs(), expv());
    end
    reset_n = 1'b1;
    start   = 1'b1;
    clock_it();
    start = 1'b0;
    n_checks++;
    if (obs() !== expv() || step_valid !== 1'b1 || fetch_start !== 1'b1) begin
      n_fail++; $display("FAIL first_start: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_instr4();
    int c0;
    c0 = m_count;
    for (int i = 0; i < 16; i++) begin
      instr_done = (m_mode == M_RUN && m_step == 3);
      clock_it();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL instr4 cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    instr_done = 1'b0;
    n_checks++;
    if (instr_count !== 4'((c0 + 4) % 16)) begin
      n_fail++; $display("FAIL instr4_count: got %0d want %0d", instr_count, (c0 + 4) % 16);
    end
  endtask

  task automatic test_full8_wait();
    int wait_left, fetches;
    wait_left = 5;
    fetches   = 0;
    instr_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      mem_wait = (m_mode == M_RUN && m_step == 2 && wait_left > 0);
      if (mem_wait) wait_left--;
      clock_it();
      if (fetch_start === 1'b1) fetches++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL full8_wait cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    mem_wait = 1'b0;
    n_checks++;
    if (fetches !== 2) begin
      n_fail++; $display("FAIL full8_fetch_count: got %0d want 2", fetches);
    end
  endtask

  task automatic test_halt();
    bit reached;
    for (int i = 0; i < 10 && m_step != 1; i++) begin
      clock_it();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL halt_pre cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    halt_req = 1'b1;
    reached  = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      instr_done = (m_mode == M_RUN && m_step == 4);
      clock_it();
      halt_req = 1'b0;
      reached  = (m_mode == M_HALT);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL halt_run cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    instr_done = 1'b0;
    n_checks++;
    if (!reached || halted !== 1'b1 || step_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_reached: got halted=%b valid=%b want 1 0", halted, step_valid);
    end
    for (int i = 0; i < 3; i++) clock_it();
    start = 1'b1;
    clock_it();
    start = 1'b0;
    n_checks++;
    if (obs() !== expv() || step !== 3'd0 || fetch_start !== 1'b1) begin
      n_fail++; $display("FAIL halt_resume: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_single_step();
    single_step = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step_pulse = (i == 8 || i == 16);
      halt_req   = (i == 24);
      instr_done = (m_mode == M_RUN && m_step == 2);
      clock_it();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL single_step cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    step_pulse = 1'b0; halt_req = 1'b0; instr_done = 1'b0; single_step = 1'b0;
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL pause_halt: got halted=%b want 1", halted);
    end
    start = 1'b1;
    clock_it();
    start = 1'b0;
  endtask

  task automatic test_wrap();
    bit saw_wrap;
    logic [CW-1:0] prev;
    saw_wrap   = 0;
    prev       = instr_count;
    instr_done = 1'b1;
    for (int i = 0; i < 17; i++) begin
      clock_it();
      if (prev == 4'd15 && instr_count == 4'd0) saw_wrap = 1;
      prev = instr_count;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL wrap cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    instr_done = 1'b0;
    n_checks++;
    if (saw_wrap !== 1'b1) begin
      n_fail++; $display("FAIL wrap_seen: got %b want 1", saw_wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(7) == 0);
      halt_req   = ($urandom_range(15) == 0);
      step_pulse = ($urandom_range(3) == 0);
      mem_wait   = ($urandom_range(3) == 0);
      instr_done = ($urandom_range(3) == 0);
      if ($urandom_range(19) == 0) single_step = ~single_step;
      clock_it();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, obs(), expv());
      end
    end
    start = 1'b0; halt_req = 1'b0; step_pulse = 1'b0;
    mem_wait = 1'b0; instr_done = 1'b0; single_step = 1'b0;
  endtask

  task automatic test_async_reset();
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    clock_it();
    start = 1'b0;
    for (int i = 0; i < 10 && m_step != 5; i++) clock_it();
    mem_wait = 1'b1;
    clock_it();
    clock_it();
    n_checks++;
    if (obs() !== expv() || step !== 3'd5) begin
      n_fail++; $display("FAIL pre_reset_hold: got %h want %h", obs(), expv());
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== 10'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs(), 10'd0);
    end
    @(negedge clk);
    mem_wait = 1'b0;
    reset_n  = 1'b1;
    clock_it();
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want %h", obs(), expv());
    end
  endtask

  initial begin
    test_reset();
    test_instr4();
    test_full8_wait();
    test_halt();
    test_single_step();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
